// File: rtl/mem_bus_pkg.sv
// rtl/mem_bus_pkg.sv - shared types and default address map for the memory bus arbiter
package mem_bus_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, TURN} state_t;
  typedef enum logic [1:0] {TGT_NONE, TGT_ROM, TGT_RAM, TGT_IO} target_t;

  localparam logic [31:0] DEF_ROM_LIMIT = 32'h0000_1000;
  localparam logic [31:0] DEF_IO_BASE   = 32'h0000_00FE;
  localparam int          DEF_IO_SIZE   = 2;
  localparam int          WAIT_W        = 4;

endpackage

// File: rtl/mem_bus_decode.sv
// rtl/mem_bus_decode.sv - address to target decode with error flag for fetch and data ports
module mem_bus_decode
  import mem_bus_pkg::*;
#(
  parameter logic [31:0] ROM_LIMIT = DEF_ROM_LIMIT,
  parameter logic [31:0] IO_BASE   = DEF_IO_BASE,
  parameter int          IO_SIZE   = DEF_IO_SIZE
) (
  input  logic [31:0] addr,
  input  logic        is_fetch,
  input  logic        we,
  output target_t     target,
  output logic        err
);

  logic in_io;
  logic in_rom;

  // Unsigned wrap makes addresses below IO_BASE fall outside the window.
  assign in_io  = (addr - IO_BASE) < 32'(IO_SIZE);
  assign in_rom = addr < ROM_LIMIT;

  always_comb begin
    target = TGT_NONE;
    err    = 1'b0;
    if (is_fetch) begin
      if (in_rom) target = TGT_ROM;
      else        err    = 1'b1;
    end else if (in_io) begin
      target = TGT_IO;
    end else if (in_rom) begin
      if (we) err    = 1'b1;
      else    target = TGT_ROM;
    end else begin
      target = TGT_RAM;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - fetch/data arbiter driving the shared ROM/RAM/GPIO bus with wait states
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter logic [31:0] ROM_LIMIT = DEF_ROM_LIMIT,
  parameter logic [31:0] IO_BASE   = DEF_IO_BASE,
  parameter int          IO_SIZE   = DEF_IO_SIZE,
  parameter int          ROM_WAIT  = 1,
  parameter int          RAM_WAIT  = 0,
  parameter int          IO_WAIT   = 0
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [63:0] dm_wdata,
  output logic        dm_ack,
  output logic [63:0] dm_rdata,
  output logic        dm_err,
  output logic [31:0] bus_addr,
  output logic [63:0] bus_wdata,
  input  logic [63:0] bus_rdata,
  output logic        rom_cs,
  output logic        ram_cs,
  output logic        io_cs,
  output logic        bus_oe,
  output logic        bus_we
);

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic [1:0]        streak_q, streak_d;
  target_t           tgt_q, tgt_d;
  logic              we_q, we_d;
  logic              own_dm_q, own_dm_d;

  target_t           cs_d;
  logic              oe_d, bwe_d, if_ack_d, dm_ack_d, if_err_d, dm_err_d;
  logic [31:0]       addr_d, if_rdata_d;
  logic [63:0]       wdata_d, dm_rdata_d;

  logic              dm_win;
  logic [31:0]       sel_addr;
  target_t           dec_tgt;
  logic              dec_err;

  function automatic logic [WAIT_W-1:0] wait_of(input target_t t);
    unique case (t)
      TGT_ROM: wait_of = WAIT_W'(ROM_WAIT);
      TGT_RAM: wait_of = WAIT_W'(RAM_WAIT);
      TGT_IO:  wait_of = WAIT_W'(IO_WAIT);
      default: wait_of = '0;
    endcase
  endfunction

  // Data wins unless it has already taken two grants in a row over a waiting fetch.
  assign dm_win   = dm_req && !(if_req && streak_q == 2'd2);
  assign sel_addr = dm_win ? dm_addr : if_addr;

  mem_bus_decode #(
    .ROM_LIMIT (ROM_LIMIT),
    .IO_BASE   (IO_BASE),
    .IO_SIZE   (IO_SIZE)
  ) u_decode (
    .addr     (sel_addr),
    .is_fetch (!dm_win),
    .we       (dm_we),
    .target   (dec_tgt),
    .err      (dec_err)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    streak_d   = streak_q;
    tgt_d      = tgt_q;
    we_d       = we_q;
    own_dm_d   = own_dm_q;
    addr_d     = bus_addr;
    wdata_d    = bus_wdata;
    if_rdata_d = if_rdata;
    dm_rdata_d = dm_rdata;
    cs_d       = TGT_NONE;
    oe_d       = 1'b0;
    bwe_d      = 1'b0;
    if_ack_d   = 1'b0;
    dm_ack_d   = 1'b0;
    if_err_d   = 1'b0;
    dm_err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (if_req || dm_req) begin
          addr_d   = sel_addr;
          own_dm_d = dm_win;
          we_d     = dm_win && dm_we;
          if (dm_win) begin
            wdata_d  = dm_wdata;
            streak_d = if_req ? streak_q + 2'd1 : 2'd0;
          end else begin
            streak_d = 2'd0;
          end
          if (dec_err) begin
            state_d  = TURN;
            tgt_d    = TGT_NONE;
            if_ack_d = !dm_win;
            if_err_d = !dm_win;
            dm_ack_d = dm_win;
            dm_err_d = dm_win;
          end else begin
            state_d = ACCESS;
            tgt_d   = dec_tgt;
            cnt_d   = wait_of(dec_tgt);
            cs_d    = dec_tgt;
            oe_d    = !(dm_win && dm_we);
            bwe_d   = dm_win && dm_we;
          end
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          state_d  = TURN;
          if_ack_d = !own_dm_q;
          dm_ack_d = own_dm_q;
          if (!we_q) begin
            if (own_dm_q) dm_rdata_d = bus_rdata;
            else          if_rdata_d = bus_rdata[31:0];
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
          cs_d  = tgt_q;
          oe_d  = !we_q;
          bwe_d = we_q;
        end
      end
      TURN:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      streak_q  <= 2'd0;
      tgt_q     <= TGT_NONE;
      we_q      <= 1'b0;
      own_dm_q  <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      rom_cs    <= 1'b0;
      ram_cs    <= 1'b0;
      io_cs     <= 1'b0;
      bus_oe    <= 1'b0;
      bus_we    <= 1'b0;
      if_ack    <= 1'b0;
      dm_ack    <= 1'b0;
      if_err    <= 1'b0;
      dm_err    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      streak_q  <= streak_d;
      tgt_q     <= tgt_d;
      we_q      <= we_d;
      own_dm_q  <= own_dm_d;
      bus_addr  <= addr_d;
      bus_wdata <= wdata_d;
      if_rdata  <= if_rdata_d;
      dm_rdata  <= dm_rdata_d;
      rom_cs    <= (cs_d == TGT_ROM);
      ram_cs    <= (cs_d == TGT_RAM);
      io_cs     <= (cs_d == TGT_IO);
      bus_oe    <= oe_d;
      bus_we    <= bwe_d;
      if_ack    <= if_ack_d;
      dm_ack    <= dm_ack_d;
      if_err    <= if_err_d;
      dm_err    <= dm_err_d;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - directed self-checking bench for mem_bus_arbiter
module tb_mem_bus_arbiter;
  import mem_bus_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        if_err;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [63:0] dm_wdata;
  logic        dm_ack;
  logic [63:0] dm_rdata;
  logic        dm_err;
  logic [31:0] bus_addr;
  logic [63:0] bus_wdata;
  logic [63:0] bus_rdata;
  logic        rom_cs, ram_cs, io_cs, bus_oe, bus_we;

  int checks   = 0;
  int failures = 0;

  mem_bus_arbiter dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_ack    (if_ack),
    .if_rdata  (if_rdata),
    .if_err    (if_err),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_ack    (dm_ack),
    .dm_rdata  (dm_rdata),
    .dm_err    (dm_err),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .rom_cs    (rom_cs),
    .ram_cs    (ram_cs),
    .io_cs     (io_cs),
    .bus_oe    (bus_oe),
    .bus_we    (bus_we)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // {rom_cs, ram_cs, io_cs, bus_oe, bus_we, if_ack, dm_ack, if_err, dm_err}
  function automatic logic [8:0] ctl();
    return {rom_cs, ram_cs, io_cs, bus_oe, bus_we, if_ack, dm_ack, if_err, dm_err};
  endfunction

  logic [2:0] prev_cs, cur_cs;
  logic [5:0] grants;
  int         nack, bad_overlap, bad_run, run;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0;
    dm_addr = '0; dm_wdata = '0; bus_rdata = '0;
    repeat (3) tick();
    chk("reset_ctl", 64'(ctl()), 64'd0);
    chk("reset_addr", 64'(bus_addr), 64'd0);
    chk("reset_wdata", bus_wdata, 64'd0);
    chk("reset_rdata", {32'(if_rdata), 32'(dm_rdata)}, 64'd0);
    chk("reset_state", 64'(dut.state_q), 64'(IDLE));
    reset_n = 1'b1;
    tick();

    // ROM fetch with one wait state
    bus_rdata = 64'h0123_4567_F80F_E3E0;
    if_req = 1'b1; if_addr = 32'h0000_0004;
    tick();
    chk("fetch_n1_ctl", 64'(ctl()), 64'(9'b1_0010_0000));
    chk("fetch_n1_addr", 64'(bus_addr), 64'h4);
    tick();
    chk("fetch_n2_ctl", 64'(ctl()), 64'(9'b1_0010_0000));
    tick();
    chk("fetch_n3_ctl", 64'(ctl()), 64'(9'b0_0000_1000));
    chk("fetch_rdata", 64'(if_rdata), 64'hF80F_E3E0);
    if_req = 1'b0;
    tick();
    chk("fetch_n4_ctl", 64'(ctl()), 64'd0);

    // GPIO data write
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h0000_00FF; dm_wdata = 64'd4;
    tick();
    chk("iowr_n1_ctl", 64'(ctl()), 64'(9'b0_0101_0000));
    chk("iowr_wdata", bus_wdata, 64'd4);
    tick();
    chk("iowr_n2_ctl", 64'(ctl()), 64'(9'b0_0000_0100));
    chk("iowr_rdata_kept", dm_rdata, 64'd0);
    dm_req = 1'b0;
    tick();
    chk("iowr_n3_ctl", 64'(ctl()), 64'd0);

    // Error requests: data write to ROM, fetch outside ROM
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h0000_0010;
    tick();
    chk("romwr_err_ctl", 64'(ctl()), 64'(9'b0_0000_0101));
    dm_req = 1'b0; dm_we = 1'b0;
    tick();
    chk("romwr_after_ctl", 64'(ctl()), 64'd0);
    if_req = 1'b1; if_addr = 32'h0000_2000;
    tick();
    chk("fetch_err_ctl", 64'(ctl()), 64'(9'b0_0000_1010));
    if_req = 1'b0;
    tick();
    chk("fetch_err_after_ctl", 64'(ctl()), 64'd0);

    // Both ports requesting continuously
    bus_rdata = 64'hAAAA_BBBB_CCCC_DDDD;
    if_req = 1'b1; if_addr = 32'h0000_0008;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0000_2000;
    prev_cs = '0; grants = '0; nack = 0; bad_overlap = 0; bad_run = 0; run = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      cur_cs = {rom_cs, ram_cs, io_cs};
      if ($countones(cur_cs) > 1 || (if_ack && dm_ack)) bad_overlap++;
      if (prev_cs != 3'b000 && cur_cs != 3'b000 && cur_cs != prev_cs) bad_overlap++;
      if ((if_ack || dm_ack) && cur_cs != 3'b000) bad_overlap++;
      if (cur_cs != 3'b000 && cur_cs == prev_cs) run++;
      else if (cur_cs != 3'b000) run = 1;
      else if (prev_cs != 3'b000) begin
        if (run != ((prev_cs == 3'b100) ? 2 : 1)) bad_run++;
        run = 0;
      end
      prev_cs = cur_cs;
      if ((dm_ack || if_ack) && nack < 6) begin
        grants = {grants[4:0], dm_ack};
        nack++;
      end
    end
    chk("arb_ack_count", 64'(nack), 64'd6);
    chk("arb_order", 64'(grants), 64'(6'b110110));
    chk("arb_overlap", 64'(bad_overlap), 64'd0);
    chk("arb_cs_len", 64'(bad_run), 64'd0);
    chk("arb_dm_rdata", dm_rdata, 64'hAAAA_BBBB_CCCC_DDDD);
    chk("arb_if_rdata", 64'(if_rdata), 64'hCCCC_DDDD);
    if_req = 1'b0; dm_req = 1'b0;
    repeat (6) tick();
    chk("arb_drained_ctl", 64'(ctl()), 64'd0);

    // Reset asserted in the middle of a ROM read
    if_req = 1'b1; if_addr = 32'h0000_0004;
    tick();
    chk("rst_mid_cs", 64'(rom_cs), 64'd1);
    reset_n = 1'b0; if_req = 1'b0;
    tick();
    chk("rst_mid_ctl", 64'(ctl()), 64'd0);
    chk("rst_mid_state", 64'(dut.state_q), 64'(IDLE));
    chk("rst_mid_regs", {32'(bus_addr), 32'(if_rdata)}, 64'd0);
    reset_n = 1'b1;
    tick();
    bus_rdata = 64'h0000_0000_1111_2222;
    if_req = 1'b1; if_addr = 32'h0000_0004;
    repeat (3) tick();
    chk("post_rst_ack", 64'({if_ack, if_err, rom_cs}), 64'(3'b100));
    chk("post_rst_rdata", 64'(if_rdata), 64'h1111_2222);
    if_req = 1'b0;
    tick();

    // Data request dropped right after grant
    bus_rdata = 64'h5555_6666_7777_8888;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0000_3000;
    tick();
    chk("drop_n1_ctl", 64'(ctl()), 64'(9'b0_1010_0000));
    dm_req = 1'b0;
    nack = 0; bad_run = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (dm_ack) nack++;
      if (rom_cs || ram_cs || io_cs) bad_run++;
    end
    chk("drop_ack_once", 64'(nack), 64'd1);
    chk("drop_no_second", 64'(bad_run), 64'd0);
    chk("drop_rdata", dm_rdata, 64'h5555_6666_7777_8888);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
